mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-port controller that shares the single asynchronous 16-bit, 20-bit-address memory between instruction fetch (port 0) and data load/store (port 1).
- Converts clocked request/done handshakes into the memory's level strobes (RRq/WRq), the OK completion flag and the Ack acknowledge.
- Round-robin arbitration; one memory transaction in flight at a time.
- Sits between the CPU core and the memory, as the only driver of the memory bus.

Parameters:
MIN_WAIT, 3, minimum cycles a strobe is held before OK is trusted; must be >= 3 to mask stale OK through the synchronizer.
TIMEOUT_CYCLES, 255, strobe cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
P0Req  input  1  port 0 request; held with We/Addr/WData stable until P0Done
P0We  input  1  port 0: 1 = write, 0 = read
P0Addr  input  20  port 0 word address
P0WData  input  16  port 0 write data
P0RData  output  16  port 0 read data, valid while P0Done=1
P0Done  output  1  port 0 one-cycle completion pulse
P1Req, P1We, P1Addr, P1WData, P1RData, P1Done  same as port 0, for port 1
MemAddr  output  20  memory address
MemRRq  output  1  memory read strobe
MemWRq  output  1  memory write strobe
MemAck  output  1  one-cycle acknowledge to memory after each transaction
MemData  inout  16  memory data bus; driven only while MemWRq=1, otherwise Z
MemOK  input  1  memory completion flag, asynchronous
Busy  output  1  transaction in progress (state != IDLE)
Err  output  1  timeout abort pulse; constant 0 without MEM_TIMEOUT_EN

Behaviour:
- All outputs are registered.
- Reset values:
  - State = IDLE; MemRRq = MemWRq = MemAck = 0; MemAddr = 0; MemData = Z.
  - P0Done = P1Done = 0; P0RData = P1RData = 0; Busy = 0; Err = 0.
  - LastGrant = 1, so port 0 wins the first tie.
- Reset mid-operation drops the strobes immediately, releases MemData and produces no Done.
- MemOK passes through a 2-flop synchronizer to OkS.
- Arbitration in IDLE:
  - If only one Req is high, that port is granted.
  - If both are high, the port != LastGrant is granted.
  - LastGrant updates on grant.
  - The granted port's Addr, We and WData are latched.
- State machine:
  - IDLE: on a grant, go to SETUP. MemAddr and the write-data register load at this transition.
  - SETUP (1 cycle): address and write data are stable; strobes stay low; go to STROBE.
  - STROBE:
    - Raise MemRRq if read, MemWRq if write; never both.
    - Cnt increments from 1 each cycle.
    - When Cnt >= MIN_WAIT and OkS = 1, go to RELEASE; on a read, capture MemData into the granted port's RData on the same edge.
  - RELEASE (1 cycle): strobes low; MemAck = 1; granted port's Done = 1; go to IDLE.
- Latency: Req first seen high in cycle 0 with MemOK already high gives Done in cycle 2 + MIN_WAIT (cycle 5 at default).
- A slower OK extends STROBE by whole cycles; there is no upper bound without the macro.
- Back-to-back operation:
  - A requester that keeps Req high after Done starts a new transaction; its first IDLE cycle is the cycle after RELEASE.
  - Throughput is one transaction per 3 + MIN_WAIT cycles (IDLE, SETUP, MIN_WAIT STROBE cycles, RELEASE).
- A Req dropped before Done is a protocol violation; the transaction still completes with the latched values.
- The non-granted port's Done stays 0, and its RData holds its last value.
- MemData is driven from the latched write data only while MemWRq = 1, and released on the same edge that drops MemWRq.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - If Cnt reaches TIMEOUT_CYCLES in STROBE without OkS, drop the strobe and go to RELEASE.
  - Err = 1 and the granted Done = 1 for that cycle; MemAck stays 0.
  - RData is unchanged; LastGrant still updates.
- Undefined: no timeout counter compare; STROBE waits indefinitely; Err is tied to 0.

Test Plan:
- Reset asserted mid-STROBE of a write -> MemWRq=0, MemData=Z and Busy=0 asynchronously; no Done pulse.
- P0 read at 0x00010 with the memory holding 0x1234 and MemOK high -> MemRRq high in cycles 2-4; P0Done and MemAck high in cycle 5 with P0RData=0x1234.
- P1 write 0xBEEF to 0xFFFFF -> MemData=0xBEEF exactly while MemWRq=1; a subsequent P1 read of 0xFFFFF returns 0xBEEF.
- P0Req and P1Req both held high for 4 transactions -> grants go P0, P1, P0, P1; a new IDLE follows each Done; no cycle has both strobes high.
- MemOK held low for 10 cycles after the strobe rises -> STROBE is extended; Done follows 2 cycles after OK rises (synchronizer); Err stays 0.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, MemOK stuck low -> strobe drops after cycle 8 of STROBE; Err=1 and Done=1 for one cycle; MemAck=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU-side request ports and memory control/status signals of the arbiter.
// The tristate memory data bus is not carried here; it stays a plain inout net on the arbiter.
// master = requester/memory environment side, slave = arbiter side.
interface mem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [19:0] p0_addr;
  logic [15:0] p0_wdata;
  logic [15:0] p0_rdata;
  logic        p0_done;
  logic        p1_req;
  logic        p1_we;
  logic [19:0] p1_addr;
  logic [15:0] p1_wdata;
  logic [15:0] p1_rdata;
  logic        p1_done;
  logic [19:0] mem_addr;
  logic        mem_rrq;
  logic        mem_wrq;
  logic        mem_ack;
  logic        mem_ok;
  logic        busy;
  logic        err;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_ok,
    input  p0_rdata, p0_done, p1_rdata, p1_done, mem_addr, mem_rrq, mem_wrq, mem_ack, busy, err
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_ok,
    output p0_rdata, p0_done, p1_rdata, p1_done, mem_addr, mem_rrq, mem_wrq, mem_ack, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port front end driving one asynchronous 16-bit memory; optional MEM_TIMEOUT_EN aborts stuck strobes.
// Latency: Done is 2 + MIN_WAIT cycles after Req is first seen with OK already high; one transaction per 3 + MIN_WAIT cycles.
// Backpressure: a port holds Req until its Done pulse; the other port waits in IDLE; a slow OK stretches the strobe.
module mem_arbiter #(
  parameter int MIN_WAIT       = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  inout  wire  [15:0]  mem_data
);

  // The strobe counter only has to reach the larger of its two thresholds; it saturates there.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > MIN_WAIT) ? TIMEOUT_CYCLES : MIN_WAIT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  state_t        state;
  logic          ok_meta;
  logic          ok_s;
  logic          last_grant;
  logic          gnt;
  logic          lat_we;
  logic [15:0]   wdata_q;
  logic [CW-1:0] cnt;
  logic          grant_vld;
  logic          grant_sel;
  logic          sel_we;
  logic [19:0]   sel_addr;
  logic [15:0]   sel_wdata;
  logic          ok_done;
  logic          timeout;

  // Only this block drives the memory data bus, and only while the write strobe is up.
  assign mem_data = bus.mem_wrq ? wdata_q : 16'bz;

  // Before MIN_WAIT strobe cycles a high OkS may still be left over from the previous access.
  assign ok_done = (cnt >= CW'(MIN_WAIT)) && ok_s;

`ifdef MEM_TIMEOUT_EN
  logic err_q;
  assign timeout = (cnt >= CW'(TIMEOUT_CYCLES));
  assign bus.err = err_q;

  // Err pulses on the same edge that moves a stuck strobe into RELEASE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state == STROBE) && !ok_done && timeout;
  end
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous memory completion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_meta <= 1'b0;
      ok_s    <= 1'b0;
    end else begin
      ok_meta <= bus.mem_ok;
      ok_s    <= ok_meta;
    end
  end

  // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    grant_vld = bus.p0_req | bus.p1_req;
    if (bus.p0_req && bus.p1_req) grant_sel = ~last_grant;
    else                          grant_sel = bus.p1_req;
    sel_we    = grant_sel ? bus.p1_we    : bus.p0_we;
    sel_addr  = grant_sel ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = grant_sel ? bus.p1_wdata : bus.p0_wdata;
  end

  // Transaction sequencer; every memory-side and CPU-side output is a register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      gnt          <= 1'b0;
      lat_we       <= 1'b0;
      wdata_q      <= '0;
      cnt          <= '0;
      bus.mem_addr <= '0;
      bus.mem_rrq  <= 1'b0;
      bus.mem_wrq  <= 1'b0;
      bus.mem_ack  <= 1'b0;
      bus.p0_done  <= 1'b0;
      bus.p1_done  <= 1'b0;
      bus.p0_rdata <= '0;
      bus.p1_rdata <= '0;
      bus.busy     <= 1'b0;
    end else begin
      bus.mem_ack <= 1'b0;
      bus.p0_done <= 1'b0;
      bus.p1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            state        <= SETUP;
            gnt          <= grant_sel;
            last_grant   <= grant_sel;
            lat_we       <= sel_we;
            bus.mem_addr <= sel_addr;
            wdata_q      <= sel_wdata;
            bus.busy     <= 1'b1;
          end
        end
        SETUP: begin
          state       <= STROBE;
          bus.mem_rrq <= ~lat_we;
          bus.mem_wrq <= lat_we;
          cnt         <= CW'(1);
        end
        STROBE: begin
          if (cnt != CW'(CNT_MAX)) cnt <= cnt + CW'(1);
          if (ok_done) begin
            state       <= RELEASE;
            bus.mem_rrq <= 1'b0;
            bus.mem_wrq <= 1'b0;
            bus.mem_ack <= 1'b1;
            if (gnt) bus.p1_done <= 1'b1;
            else     bus.p0_done <= 1'b1;
            if (!lat_we) begin
              if (gnt) bus.p1_rdata <= mem_data;
              else     bus.p0_rdata <= mem_data;
            end
          end else if (timeout) begin
            // Abort: Done without Ack, read data left untouched.
            state       <= RELEASE;
            bus.mem_rrq <= 1'b0;
            bus.mem_wrq <= 1'b0;
            if (gnt) bus.p1_done <= 1'b1;
            else     bus.p0_done <= 1'b1;
          end
        end
        RELEASE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
